// File: rtl/quad_pkg.sv
// Shared types and arithmetic helpers for the quadrature decoder.
// Position helpers take the legal range as arguments so any channel width can reuse them.
package quad_pkg;

  typedef enum logic [1:0] {
    GRAY_NONE,
    GRAY_UP,
    GRAY_DOWN,
    GRAY_ILLEGAL
  } gray_t;

  localparam int TIMER_W  = 8;
  localparam int FILTER_W = 4;

  // Position of an {A,B} level along the up-counting cycle 00,01,11,10.
  function automatic logic [1:0] gray_index(input logic [1:0] ab);
    case (ab)
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      2'b11:   return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  function automatic gray_t gray_dir(input logic [1:0] old_ab, input logic [1:0] new_ab);
    logic [1:0] delta;
    delta = gray_index(new_ab) - gray_index(old_ab);
    case (delta)
      2'd0:    return GRAY_NONE;
      2'd1:    return GRAY_UP;
      2'd3:    return GRAY_DOWN;
      default: return GRAY_ILLEGAL;
    endcase
  endfunction

  function automatic int clamp_pos(input int value, input int lo, input int hi);
    if (value < lo) return lo;
    if (value > hi) return hi;
    return value;
  endfunction

  // Single fold is enough because a step never exceeds the range span.
  function automatic int wrap_pos(input int value, input int lo, input int hi);
    if (value > hi) return value - (hi - lo + 1);
    if (value < lo) return value + (hi - lo + 1);
    return value;
  endfunction

endpackage

// File: rtl/quad_multi_channel.sv
// One encoder channel: sync, glitch filter, priming, Gray decode, speed-dependent step
// and the position register.
module quad_channel
  import quad_pkg::*;
#(
  parameter int WIDTH        = 10,
  parameter int MIN          = 8,
  parameter int MAX          = 472,
  parameter int INIT         = 240,
  parameter int FILTER       = 2,
  parameter int ACCEL_WINDOW = 63,
  parameter int STEP_SLOW    = 1,
  parameter int STEP_FAST    = 5,
  parameter int WRAP         = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             a,
  input  logic             b,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             err_clr,
  output logic [WIDTH-1:0] count,
  output logic             step_pulse,
  output logic             dir,
  output logic             err
);

  localparam logic [WIDTH-1:0]          COUNT_RST = WIDTH'(clamp_pos(INIT, MIN, MAX));
  localparam logic [TIMER_W-1:0]        WINDOW    = TIMER_W'(ACCEL_WINDOW);
  localparam logic [FILTER_W-1:0]       FILT_LAST = FILTER_W'(FILTER - 1);
  localparam logic signed [WIDTH+1:0]   FAST_D    = (WIDTH+2)'(STEP_FAST);
  localparam logic signed [WIDTH+1:0]   SLOW_D    = (WIDTH+2)'(STEP_SLOW);

  logic [1:0]          sync1, s, s_prev, filt;
  logic [FILTER_W-1:0] fcnt;
  logic                primed;
  logic [TIMER_W-1:0]  timer;

  logic                     filt_upd;
  gray_t                    step_kind;
  logic                     is_step;
  logic signed [WIDTH+1:0]  cur, delta, target;
  int                       next_pos;
  logic [WIDTH-1:0]         load_pos;

  // The filtered level is accepted in the same cycle the counter would reach FILTER,
  // so decode sees the new level without an extra register stage.
  always_comb begin
    if (FILTER == 0) filt_upd = (s != filt);
    else             filt_upd = (s != filt) && (s == s_prev) && (fcnt == FILT_LAST);

    step_kind = (filt_upd && primed) ? gray_dir(filt, s) : GRAY_NONE;
    is_step   = (step_kind == GRAY_UP) || (step_kind == GRAY_DOWN);

    cur    = signed'({2'b00, count});
    delta  = (timer != '0) ? FAST_D : SLOW_D;
    target = (step_kind == GRAY_UP) ? cur + delta : cur - delta;
    if (WRAP != 0) next_pos = wrap_pos(int'(target), MIN, MAX);
    else           next_pos = clamp_pos(int'(target), MIN, MAX);

    load_pos = WIDTH'(clamp_pos(int'(load_value), MIN, MAX));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1      <= '0;
      s          <= '0;
      s_prev     <= '0;
      filt       <= '0;
      fcnt       <= '0;
      primed     <= 1'b0;
      timer      <= '0;
      count      <= COUNT_RST;
      step_pulse <= 1'b0;
      dir        <= 1'b0;
      err        <= 1'b0;
    end else begin
      sync1      <= {a, b};
      s          <= sync1;
      s_prev     <= s;
      step_pulse <= 1'b0;

      if (filt_upd || (s == filt) || (s != s_prev)) fcnt <= '0;
      else                                          fcnt <= fcnt + 1'b1;

      if (filt_upd) begin
        filt   <= s;
        primed <= 1'b1;
      end

      if (step_kind == GRAY_ILLEGAL) err <= 1'b1;
      else if (err_clr)              err <= 1'b0;

      // Load wins over a coincident step; the step is simply lost.
      if (load) begin
        count <= load_pos;
        timer <= '0;
      end else if (is_step) begin
        count      <= WIDTH'(next_pos);
        dir        <= (step_kind == GRAY_UP);
        step_pulse <= 1'b1;
        timer      <= WINDOW;
      end else if ((step_kind != GRAY_ILLEGAL) && (timer != '0)) begin
        timer <= timer - 1'b1;
      end
    end
  end

endmodule

// File: rtl/quad_multi.sv
// Multi-channel quadrature decoder: one independent channel per encoder,
// positions packed onto a single bus.
module quad_multi
  import quad_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int WIDTH        = 10,
  parameter int MIN          = 8,
  parameter int MAX          = 472,
  parameter int INIT         = 240,
  parameter int FILTER       = 2,
  parameter int ACCEL_WINDOW = 63,
  parameter int STEP_SLOW    = 1,
  parameter int STEP_FAST    = 5,
  parameter int WRAP         = 0
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       quad_a,
  input  logic [CHANNELS-1:0]       quad_b,
  input  logic [CHANNELS-1:0]       load,
  input  logic [WIDTH-1:0]          load_value,
  input  logic                      err_clr,
  output logic [CHANNELS*WIDTH-1:0] count,
  output logic [CHANNELS-1:0]       step_pulse,
  output logic [CHANNELS-1:0]       dir,
  output logic [CHANNELS-1:0]       err
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    quad_channel #(
      .WIDTH       (WIDTH),
      .MIN         (MIN),
      .MAX         (MAX),
      .INIT        (INIT),
      .FILTER      (FILTER),
      .ACCEL_WINDOW(ACCEL_WINDOW),
      .STEP_SLOW   (STEP_SLOW),
      .STEP_FAST   (STEP_FAST),
      .WRAP        (WRAP)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .a         (quad_a[i]),
      .b         (quad_b[i]),
      .load      (load[i]),
      .load_value(load_value),
      .err_clr   (err_clr),
      .count     (count[i*WIDTH +: WIDTH]),
      .step_pulse(step_pulse[i]),
      .dir       (dir[i]),
      .err       (err[i])
    );
  end

endmodule

// File: tb/tb_quad_multi.sv
// Bench for quad_multi: a saturating instance and a wrapping instance with a short
// accel window run side by side against an event-level position model.
module tb_quad_multi;

  localparam int CH   = 2;
  localparam int WD   = 10;
  localparam int LO   = 8;
  localparam int HI   = 472;
  localparam int FILT = 2;
  localparam int SLOW = 1;
  localparam int FAST = 5;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [CH-1:0]     quad_a, quad_b, load;
  logic [WD-1:0]     load_value;
  logic              err_clr;
  logic [CH*WD-1:0]  count_s, count_w;
  logic [CH-1:0]     step_s, step_w, dir_s, dir_w, err_s, err_w;

  quad_multi #(
    .CHANNELS(CH), .WIDTH(WD), .MIN(LO), .MAX(HI), .INIT(240), .FILTER(FILT),
    .ACCEL_WINDOW(63), .STEP_SLOW(SLOW), .STEP_FAST(FAST), .WRAP(0)
  ) dut_sat (
    .clk(clk), .reset_n(reset_n), .quad_a(quad_a), .quad_b(quad_b), .load(load),
    .load_value(load_value), .err_clr(err_clr), .count(count_s), .step_pulse(step_s),
    .dir(dir_s), .err(err_s)
  );

  quad_multi #(
    .CHANNELS(CH), .WIDTH(WD), .MIN(LO), .MAX(HI), .INIT(240), .FILTER(FILT),
    .ACCEL_WINDOW(8), .STEP_SLOW(SLOW), .STEP_FAST(FAST), .WRAP(1)
  ) dut_wrap (
    .clk(clk), .reset_n(reset_n), .quad_a(quad_a), .quad_b(quad_b), .load(load),
    .load_value(load_value), .err_clr(err_clr), .count(count_w), .step_pulse(step_w),
    .dir(dir_w), .err(err_w)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: one entry per (instance, channel)
  int         m_pos   [2][CH];
  logic       m_dir   [2][CH];
  logic       m_err   [2][CH];
  int         m_dl    [2][CH];
  logic       m_pulse [2][CH];
  logic [1:0] lvl     [CH];
  logic       primed  [CH];
  logic [15:0] exp_q[$];
  logic [15:0] rec;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int win_of(input int d);
    return (d == 0) ? 63 : 8;
  endfunction

  function automatic int sat(input int v);
    if (v < LO) return LO;
    if (v > HI) return HI;
    return v;
  endfunction

  function automatic int fold(input int d, input int v);
    int span;
    span = HI - LO + 1;
    if (d == 1) return ((v - LO) % span + span) % span + LO;
    return sat(v);
  endfunction

  function automatic logic [1:0] seq_at(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int seq_pos(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (seq_at(i) == ab) return i;
    return 0;
  endfunction

  function automatic logic [1:0] next_level(input logic [1:0] l, input logic up);
    return seq_at(seq_pos(l) + (up ? 1 : 3));
  endfunction

  function automatic logic [WD-1:0] cnt_of(input int d, input int c);
    return (d == 0) ? count_s[c*WD +: WD] : count_w[c*WD +: WD];
  endfunction
  function automatic logic pulse_of(input int d, input int c);
    return (d == 0) ? step_s[c] : step_w[c];
  endfunction
  function automatic logic dir_of(input int d, input int c);
    return (d == 0) ? dir_s[c] : dir_w[c];
  endfunction
  function automatic logic err_of(input int d, input int c);
    return (d == 0) ? err_s[c] : err_w[c];
  endfunction

  task automatic check_state(input string tag);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        check($sformatf("%s d%0d c%0d count", tag, d, c), cnt_of(d, c), m_pos[d][c]);
        check($sformatf("%s d%0d c%0d pulse", tag, d, c), pulse_of(d, c), m_pulse[d][c]);
        check($sformatf("%s d%0d c%0d dir", tag, d, c), dir_of(d, c), m_dir[d][c]);
        check($sformatf("%s d%0d c%0d err", tag, d, c), err_of(d, c), m_err[d][c]);
      end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++) begin
        m_pos[d][c] = 240; m_dir[d][c] = 1'b0; m_err[d][c] = 1'b0;
        m_dl[d][c] = -1;   m_pulse[d][c] = 1'b0;
      end
    // a channel idling at a non-zero level gets primed silently after release
    for (int c = 0; c < CH; c++) begin
      lvl[c]    = {quad_a[c], quad_b[c]};
      primed[c] = (lvl[c] != 2'b00);
    end
  endtask

  // Effect of a settled level change on channel c, taking place at clock edge ev.
  task automatic model_move(input int c, input logic [1:0] nl, input int ev,
                            input logic ld, input logic clr);
    logic was_primed;
    int   k;
    int   mag;
    was_primed = primed[c];
    k = (seq_pos(nl) - seq_pos(lvl[c]) + 4) % 4;
    primed[c] = 1'b1;
    lvl[c]    = nl;
    for (int d = 0; d < 2; d++) begin
      if (clr) for (int cc = 0; cc < CH; cc++) m_err[d][cc] = 1'b0;
      if (was_primed && k == 2) begin
        m_err[d][c] = 1'b1;
        if (ev <= m_dl[d][c]) m_dl[d][c]++;
      end
      if (ld) begin
        m_pos[d][c] = sat(int'(load_value));
        m_dl[d][c]  = -1;
      end else if (was_primed && (k == 1 || k == 3)) begin
        mag = (ev <= m_dl[d][c]) ? FAST : SLOW;
        m_pos[d][c]   = fold(d, m_pos[d][c] + ((k == 1) ? mag : -mag));
        m_dir[d][c]   = (k == 1);
        m_dl[d][c]    = ev + win_of(d);
        m_pulse[d][c] = 1'b1;
        exp_q.push_back({1'(d), 3'(c), 2'b00, WD'(m_pos[d][c])});
      end
    end
  endtask

  // scoreboard: every observed pulse must match the next expected step record
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++)
        if (pulse_of(d, c) === 1'b1) begin
          check("pulse_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            rec = {1'(d), 3'(c), 2'b00, cnt_of(d, c)};
            check("pulse_record", rec, exp_q.pop_front());
          end
        end
  end

  // driver tasks: all start just after a rising edge
  task automatic move(input int c, input logic [1:0] nl, input int hold,
                      input logic ld, input logic clr);
    int ev;
    ev = cyc + 3 + FILT;
    quad_a[c] = nl[1];
    quad_b[c] = nl[0];
    repeat (2 + FILT) @(posedge clk);
    @(negedge clk);
    check_state("before");
    load[c] = ld;
    err_clr = clr;
    model_move(c, nl, ev, ld, clr);
    @(posedge clk);
    @(negedge clk);
    check_state("event");
    load    = '0;
    err_clr = 1'b0;
    for (int d = 0; d < 2; d++) for (int cc = 0; cc < CH; cc++) m_pulse[d][cc] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_state("after");
    repeat (hold) @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic glitch(input int c);
    quad_a[c] = ~quad_a[c];
    repeat (2) @(posedge clk);
    #1 quad_a[c] = ~quad_a[c];
    repeat (FILT + 6) @(posedge clk);
    @(negedge clk);
    check_state("glitch");
    @(posedge clk); #1;
  endtask

  task automatic load_only(input logic [CH-1:0] mask, input logic [WD-1:0] val);
    load_value = val;
    load       = mask;
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < CH; c++)
        if (mask[c]) begin
          m_pos[d][c] = sat(int'(val));
          m_dl[d][c]  = -1;
        end
    @(posedge clk);
    @(negedge clk);
    load = '0;
    check_state("load");
    @(posedge clk); #1;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    for (int d = 0; d < 2; d++) for (int c = 0; c < CH; c++) m_err[d][c] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    err_clr = 1'b0;
    check_state("err_clr");
    @(posedge clk); #1;
  endtask

  task automatic random_ops(input int n);
    int c, sel, hold;
    for (int it = 0; it < n; it++) begin
      c    = $urandom_range(0, CH - 1);
      sel  = $urandom_range(0, 99);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 70) : $urandom_range(0, 6);
      if (sel < 60) begin
        move(c, next_level(lvl[c], 1'($urandom_range(0, 1))), hold, 1'b0, 1'b0);
      end else if (sel < 66) begin
        load_value = WD'($urandom_range(0, 1023));
        move(c, next_level(lvl[c], 1'($urandom_range(0, 1))), hold, 1'b1, 1'b0);
      end else if (sel < 74) begin
        move(c, lvl[c] ^ 2'b11, hold, 1'b0, 1'($urandom_range(0, 1)));
      end else if (sel < 82) begin
        load_only(CH'($urandom_range(1, (1 << CH) - 1)), WD'($urandom_range(0, 1023)));
      end else if (sel < 88) begin
        clear_err();
      end else begin
        glitch(c);
      end
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    quad_a     = '1;
    quad_b     = '1;
    load       = '0;
    load_value = '0;
    err_clr    = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_state("reset");
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      check_state("prime");
    end
    @(posedge clk); #1;

    // slow up steps on ch0, then fast down run into the floor on ch1
    for (int i = 0; i < 4; i++) move(0, next_level(lvl[0], 1'b1), 20, 1'b0, 1'b0);
    for (int i = 0; i < 56; i++) move(1, next_level(lvl[1], 1'b0), 0, 1'b0, 1'b0);
    for (int i = 0; i < 50; i++) move(0, next_level(lvl[0], 1'b1), 0, 1'b0, 1'b0);

    glitch(0);
    glitch(1);

    // illegal double-edge, then err_clr colliding with a second illegal change
    move(0, lvl[0] ^ 2'b11, 5, 1'b0, 1'b0);
    move(0, lvl[0] ^ 2'b11, 5, 1'b0, 1'b1);
    clear_err();

    // load beats a coincident step; the following step is slow
    load_value = 10'd500;
    move(0, next_level(lvl[0], 1'b1), 0, 1'b1, 1'b0);
    move(0, next_level(lvl[0], 1'b1), 3, 1'b0, 1'b0);
    load_only(2'b11, 10'd3);
    load_only(2'b10, 10'd300);

    random_ops(160);

    // asynchronous reset in the middle of a pending step
    quad_a[1] = ~quad_a[1];
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    model_reset();
    check_state("async_reset");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check_state("reprime");
    @(posedge clk); #1;

    random_ops(40);

    repeat (4) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
